// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N producer streams in, one registered stream out.
// The slave modport is the mux; the master modport is the producers and consumer around it.
interface stream_mux_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel streaming mux with run-time round-robin / fixed-priority arbitration
// feeding a single registered output entry.
module stream_mux_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rr_en,
    stream_mux_rr_if.slave     bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] ch_data [N];
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic             load;

    logic             vld_p0;
    logic [WIDTH-1:0] data_p0;
    logic [SEL_W-1:0] sel_p0;
    logic [SEL_W-1:0] ptr;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // Search starts at ptr in round-robin mode and at channel 0 otherwise.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rr_en) cand = SEL_W'((int'(ptr) + k) % N);
            else       cand = SEL_W'(k);
            if (!found && bus.in_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    assign load         = !vld_p0 || bus.out_ready;
    assign bus.in_ready = (rst_n && load) ? grant : '0;

    // Output stage: load on grant, drain when the consumer takes the word, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            sel_p0  <= '0;
            ptr     <= '0;
        end else if (load && found) begin
            vld_p0  <= 1'b1;
            data_p0 <= ch_data[gidx];
            sel_p0  <= gidx;
            ptr     <= SEL_W'((int'(gidx) + 1) % N);
        end else if (bus.out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
    assign bus.out_sel   = sel_p0;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N=4, WIDTH=8): reset, arbitration modes,
// backpressure, pointer wrap and asynchronous reset mid-stream.
module tb_stream_mux_rr;
    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    logic rr_en;
    int   tests;
    int   fails;

    stream_mux_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

    stream_mux_rr #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rr_en (rr_en),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rr_en = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        tick();
        tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        tests++; if (bus.out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel got=%0d exp=0", bus.out_sel); end
        rst_n = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL release_in_ready got=%b exp=0001", bus.in_ready); end
        tick();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0)
            begin fails++; $display("FAIL first_load got v=%b s=%0d d=%h exp v=1 s=0 d=a0", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [4];
        logic [7:0] exp_dat [4];
        exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{8'hA1, 8'hA2, 8'hA3, 8'hA0};
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[k] || bus.out_data !== exp_dat[k])
                begin fails++; $display("FAIL rr_step%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", k, bus.out_valid, bus.out_sel, bus.out_data, exp_sel[k], exp_dat[k]); end
        end
    endtask

    task automatic test_fixed_priority();
        rr_en = 1'b0;
        bus.in_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (bus.out_sel !== 2'd1 || bus.out_data !== 8'hA1)
                begin fails++; $display("FAIL fixed_ch1_%0d got s=%0d d=%h exp s=1 d=a1", k, bus.out_sel, bus.out_data); end
        end
        bus.in_valid = 4'b1100;
        tick();
        tests++; if (bus.out_sel !== 2'd2 || bus.out_data !== 8'hA2)
            begin fails++; $display("FAIL fixed_ch2 got s=%0d d=%h exp s=2 d=a2", bus.out_sel, bus.out_data); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL bp_in_ready got=%b exp=0000", bus.in_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 8'hA2 || bus.in_ready !== 4'b0000)
                begin fails++; $display("FAIL bp_hold%0d got v=%b s=%0d d=%h r=%b exp v=1 s=2 d=a2 r=0000", k, bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready); end
        end
        bus.in_valid  = 4'b1000;
        bus.out_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 4'b1000) begin fails++; $display("FAIL bp_release_ready got=%b exp=1000", bus.in_ready); end
        tick();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3 || bus.out_data !== 8'hA3)
            begin fails++; $display("FAIL bp_no_bubble got v=%b s=%0d d=%h exp v=1 s=3 d=a3", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    task automatic test_wrap_skip();
        rr_en = 1'b1;
        bus.in_valid = 4'b0100;
        tick();
        tests++; if (bus.out_sel !== 2'd2) begin fails++; $display("FAIL wrap_setup got s=%0d exp s=2", bus.out_sel); end
        bus.in_valid = 4'b0011;
        tick();
        tests++; if (bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0)
            begin fails++; $display("FAIL wrap_skip0 got s=%0d d=%h exp s=0 d=a0", bus.out_sel, bus.out_data); end
        tick();
        tests++; if (bus.out_sel !== 2'd1 || bus.out_data !== 8'hA1)
            begin fails++; $display("FAIL wrap_skip1 got s=%0d d=%h exp s=1 d=a1", bus.out_sel, bus.out_data); end
        bus.in_valid = 4'b1000;
        tick();
        tests++; if (bus.out_sel !== 2'd3 || bus.out_data !== 8'hA3)
            begin fails++; $display("FAIL wrap_ch3 got s=%0d d=%h exp s=3 d=a3", bus.out_sel, bus.out_data); end
        bus.in_valid = 4'b0000;
        tick();
        tests++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd3 || bus.out_data !== 8'hA3)
            begin fails++; $display("FAIL drain_hold got v=%b s=%0d d=%h exp v=0 s=3 d=a3", bus.out_valid, bus.out_sel, bus.out_data); end
        bus.in_valid = 4'b1111;
        tick();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0)
            begin fails++; $display("FAIL wrap_ptr0 got v=%b s=%0d exp v=1 s=0", bus.out_valid, bus.out_sel); end
    endtask

    task automatic test_async_reset();
        bus.in_valid = 4'b0100;
        tick();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2)
            begin fails++; $display("FAIL arst_setup got v=%b s=%0d exp v=1 s=2", bus.out_valid, bus.out_sel); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h00 || bus.in_ready !== 4'b0000)
            begin fails++; $display("FAIL arst_clear got v=%b s=%0d d=%h r=%b exp v=0 s=0 d=00 r=0000", bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready); end
        tick();
        bus.in_valid = 4'b1111;
        #2;
        rst_n = 1'b1;
        tick();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0)
            begin fails++; $display("FAIL arst_restart got v=%b s=%0d d=%h exp v=1 s=0 d=a0", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        rr_en = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_wrap_skip();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the combinational 4:1 case mux: N-channel, WIDTH-bit streaming multiplexer with per-channel valid/ready handshake.
- Arbitration is round-robin or fixed-priority, selected at run time; output is a registered single-entry stage.
- Sits between several producer streams and one shared consumer, e.g. a shared bus or result port.
- Throughput: one transfer per clock when the consumer is ready.

Parameters:
- N, 4, number of input channels (N >= 1).
- WIDTH, 8, data width per channel.
- SEL_W, (N > 1 ? $clog2(N) : 1), width of channel-index signals; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rr_en  input  1  1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; combinational.
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered output data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset:
  - rst_n low asynchronously clears out_valid=0, out_data=0, out_sel=0 and the round-robin pointer ptr=0.
  - in_ready is 0 while rst_n is low.
  - Reset asserted mid-transfer discards the held word; no transfer completes in that cycle.
- Load enable: load = !out_valid || out_ready (the output stage is empty or is being drained this cycle).
- Grant (combinational, one-hot or zero):
  - rr_en=1: first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - rr_en=0: lowest i with in_valid[i]=1; ptr is ignored for selection.
  - No valid inputs: grant=0.
- in_ready[i] = load && grant[i]. At most one in_ready bit is high per cycle.
  - in_ready never depends on in_valid[j] for j≠i other than through grant.
- Transfers:
  - An input transfer occurs when in_valid[i] && in_ready[i].
  - An output transfer occurs when out_valid && out_ready.
- On each clock edge:
  - If load and any grant: out_valid<=1, out_data<=in_data[g], out_sel<=g, ptr<=(g+1) mod N. ptr is updated in both modes.
  - Else if out_ready: out_valid<=0; out_data and out_sel hold their last values.
  - Else (out_valid && !out_ready): all outputs hold stable. Producers see in_ready=0.
- Latency: one cycle from input transfer to out_valid.
- Simultaneous drain and load in the same cycle gives back-to-back output with no bubble.
- Wrap-around: ptr=N-1 and grant N-1 gives ptr=0.
- N=1: grant = in_valid[0]; out_sel is always 0.
- rr_en may change on any cycle; it takes effect on that cycle's grant.
- Implementation must be fully synchronous apart from the reset, with no latches and no combinational path from out_ready to out_*.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. Release -> the first edge loads channel 0.
- Round-robin fairness: N=4, rr_en=1, in_valid=4'b1111 constant, data i=8'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,… and out_data A0,A1,A2,A3,A0. out_valid stays 1 every cycle after the first.
- Fixed priority: rr_en=0, in_valid=4'b1110, out_ready=1 -> out_sel=1 every cycle. Drop in_valid[1] -> out_sel=2.
- Backpressure: out_ready=0 with out_valid=1 holding 8'hA2 sel=2 for 5 cycles -> outputs stable and in_ready=0. Raise out_ready -> the next word loads in the same cycle, no bubble.
- Pointer wrap and skip: rr_en=1, ptr=3 (after granting 2), in_valid=4'b0011 -> grant 0 then 1. in_valid=4'b1000 -> grant 3, then ptr=0.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1, out_sel=2 -> outputs clear immediately. After release, arbitration restarts from channel 0.
